// File: rtl/mmc_cell_monitor.sv
`default_nettype none
// ============================================================================
// Module   : mmc_cell_monitor
// Purpose  : Capacitor-voltage monitor for one MMC arm. Each of N_CH PIC
//            UART byte streams is boxcar-averaged over 2^AVG_LOG2 samples by
//            a single shared round-robin engine. The block also produces
//            per-leg pair averages and overvoltage flags with hysteresis,
//            runs an optional stale-link watchdog, and latches one fault
//            (plus the channel that caused it) for the firing logic.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   MMC_MON_STALE_EN  defined   -> per-channel watchdog counters are built;
//                                  stale[] is driven and feeds the fault latch
//                     undefined -> no counters; stale[] is tied to 0 and the
//                                  fault latch depends on ov[] only
// ----------------------------------------------------------------------------
// Ports:
//   clk_50     in   1              system clock
//   rst        in   1              synchronous active-high reset
//   rx_data    in   N_CH*W         channel i sample at [i*W +: W]
//   rx_valid   in   N_CH           one-cycle sample strobe per channel
//   clr_fault  in   1              one-cycle fault clear request
//   v_filt     out  N_CH*W         filtered voltage per channel
//   v_leg_avg  out  (N_CH/2)*W     registered pair average per leg
//   upd        out  N_CH           one-cycle pulse when v_filt[i] updates
//   ov         out  N_CH           overvoltage flag with hysteresis
//   stale      out  N_CH           no sample within TIMEOUT cycles
//   fault      out  1              latched (ov | stale)
//   fault_ch   out  clog2(N_CH)    channel that set the latch
// ============================================================================
module mmc_cell_monitor #(
  parameter int N_CH     = 6,
  parameter int W        = 8,
  parameter int AVG_LOG2 = 2,
  parameter int V_MAX    = 230,
  parameter int V_HYST   = 10,
  parameter int TIMEOUT  = 2_500_000
) (
  input  logic                      clk_50,
  input  logic                      rst,
  input  logic [N_CH*W-1:0]         rx_data,
  input  logic [N_CH-1:0]           rx_valid,
  input  logic                      clr_fault,
  output logic [N_CH*W-1:0]         v_filt,
  output logic [(N_CH/2)*W-1:0]     v_leg_avg,
  output logic [N_CH-1:0]           upd,
  output logic [N_CH-1:0]           ov,
  output logic [N_CH-1:0]           stale,
  output logic                      fault,
  output logic [$clog2(N_CH)-1:0]   fault_ch
);

  localparam int CH_W   = $clog2(N_CH);
  localparam int N_LEG  = N_CH / 2;
  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int IDX_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SUM_W  = W + AVG_LOG2;

  localparam logic [CH_W:0]    N_CH_EXT  = (CH_W + 1)'(N_CH);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [W-1:0]     OV_SET    = W'(V_MAX);
  localparam logic [W-1:0]     OV_CLR    = W'(V_MAX - V_HYST);

  // An odd channel count or a zero timeout is a configuration error; the
  // empty named block makes the intent visible in the elaborated hierarchy.
  if (((N_CH % 2) != 0) || (TIMEOUT < 1)) begin : g_param_check
  end

  // --------------------------------------------------------------------------
  // Capture: per-channel hold register plus pending bit.
  // --------------------------------------------------------------------------
  logic [W-1:0]    hold_q [N_CH];
  logic [W-1:0]    hold_d [N_CH];
  logic [N_CH-1:0] pending_q;
  logic [N_CH-1:0] pending_d;
  logic [N_CH-1:0] load_clr;

  // --------------------------------------------------------------------------
  // Engine state.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ACC  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t            state_q;
  logic [CH_W-1:0]   sel_q;
  logic [CH_W-1:0]   ptr_q;
  logic [W-1:0]      work_q;
  logic [W-1:0]      oldest_q;
  logic [W-1:0]      ring_q   [N_CH][DEPTH];
  logic [IDX_W-1:0]  widx_q   [N_CH];
  logic [SUM_W-1:0]  sum_q    [N_CH];
  logic [W-1:0]      v_filt_q [N_CH];
  logic [N_CH-1:0]   ov_q;
  logic [N_CH-1:0]   upd_q;

  // --------------------------------------------------------------------------
  // Round-robin pick: rotate pending so bit 0 is channel ptr, find the lowest
  // set bit, then rotate the offset back into a channel number.
  // --------------------------------------------------------------------------
  logic [N_CH-1:0]   pend_rot;
  logic [CH_W-1:0]   rot_off;
  logic [CH_W:0]     pick_sum;
  logic [CH_W-1:0]   pick_idx;

  always_comb begin
    pend_rot = N_CH'({pending_q, pending_q} >> ptr_q);
    rot_off  = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (pend_rot[j]) begin
        rot_off = CH_W'(j);
      end
    end
    pick_sum = {1'b0, ptr_q} + {1'b0, rot_off};
    if (pick_sum >= N_CH_EXT) begin
      pick_sum = pick_sum - N_CH_EXT;
    end
    pick_idx = pick_sum[CH_W-1:0];
  end

  // --------------------------------------------------------------------------
  // Capture next-state. A strobe on the channel being loaded keeps its
  // pending bit set so the fresh sample gets its own service later.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      load_clr[i]  = (state_q == S_LOAD) && (sel_q == CH_W'(i));
      hold_d[i]    = rx_valid[i] ? rx_data[i*W +: W] : hold_q[i];
      pending_d[i] = (pending_q[i] & ~load_clr[i]) | rx_valid[i];
    end
  end

  // --------------------------------------------------------------------------
  // Engine datapath. The subtraction is done one bit wider so the transient
  // (sum - oldest) cannot wrap; the final running sum always fits SUM_W.
  // --------------------------------------------------------------------------
  logic [SUM_W-1:0]  acc_sum;
  logic [W-1:0]      acc_filt;
  logic              ov_next;
  logic [IDX_W-1:0]  widx_inc;
  logic [CH_W-1:0]   ptr_next;

  always_comb begin
    acc_sum  = SUM_W'({1'b0, sum_q[sel_q]} + (SUM_W + 1)'(work_q)
                      - (SUM_W + 1)'(oldest_q));
    acc_filt = acc_sum[SUM_W-1:AVG_LOG2];
    if (acc_filt > OV_SET) begin
      ov_next = 1'b1;
    end else if (acc_filt < OV_CLR) begin
      ov_next = 1'b0;
    end else begin
      ov_next = ov_q[sel_q];
    end
    widx_inc = (widx_q[sel_q] == LAST_IDX) ? '0 : widx_q[sel_q] + 1'b1;
    ptr_next = (sel_q == LAST_CH) ? '0 : sel_q + 1'b1;
  end

  // --------------------------------------------------------------------------
  // Engine FSM: IDLE -> LOAD -> ACC -> OUT, four cycles per service.
  // Results are registered on the edge into OUT so v_filt, ov and the upd
  // pulse are all visible during the OUT cycle. Reset clears the ring and
  // sums, so a service interrupted by reset leaves nothing behind.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      ptr_q    <= '0;
      work_q   <= '0;
      oldest_q <= '0;
      ov_q     <= '0;
      upd_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        sum_q[i]    <= '0;
        widx_q[i]   <= '0;
        v_filt_q[i] <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          ring_q[i][d] <= '0;
        end
      end
    end else begin
      upd_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (|pending_q) begin
            sel_q   <= pick_idx;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          work_q   <= hold_q[sel_q];
          // The write index points at the oldest entry of the ring.
          oldest_q <= ring_q[sel_q][widx_q[sel_q]];
          state_q  <= S_ACC;
        end
        S_ACC: begin
          sum_q[sel_q]                 <= acc_sum;
          ring_q[sel_q][widx_q[sel_q]] <= work_q;
          widx_q[sel_q]                <= widx_inc;
          v_filt_q[sel_q]              <= acc_filt;
          ov_q[sel_q]                  <= ov_next;
          upd_q[sel_q]                 <= 1'b1;
          state_q                      <= S_OUT;
        end
        S_OUT: begin
          ptr_q   <= ptr_next;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Stale watchdog.
  // --------------------------------------------------------------------------
  logic [N_CH-1:0] stale_w;

`ifdef MMC_MON_STALE_EN
  localparam int                CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TO_CNT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      if (rx_valid[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == TO_CNT) begin
        cnt_d[i] = cnt_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      stale_w[i] = (cnt_q[i] == TO_CNT);
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign stale_w = '0;
`endif

  // --------------------------------------------------------------------------
  // Leg averages (W+1-bit sum, halved) and fault latch.
  // --------------------------------------------------------------------------
  logic [W-1:0]    leg_q [N_LEG];
  logic [W-1:0]    leg_d [N_LEG];
  logic [N_CH-1:0] flag_vec;
  logic [CH_W-1:0] flag_lo;
  logic            fault_q;
  logic            fault_d;
  logic [CH_W-1:0] fault_ch_q;
  logic [CH_W-1:0] fault_ch_d;

  always_comb begin
    for (int k = 0; k < N_LEG; k++) begin
      leg_d[k] = W'(({1'b0, v_filt_q[2*k]} + {1'b0, v_filt_q[2*k+1]}) >> 1);
    end
  end

  always_comb begin
    flag_vec = ov_q | stale_w;
    flag_lo  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (flag_vec[i]) begin
        flag_lo = CH_W'(i);
      end
    end
    fault_d    = fault_q;
    fault_ch_d = fault_ch_q;
    if (!fault_q) begin
      // fault_ch is only captured on the setting edge.
      if (|flag_vec) begin
        fault_d    = 1'b1;
        fault_ch_d = flag_lo;
      end
    end else if (clr_fault && !(|flag_vec)) begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      pending_q  <= '0;
      fault_q    <= 1'b0;
      fault_ch_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hold_q[i] <= '0;
      end
      for (int k = 0; k < N_LEG; k++) begin
        leg_q[k] <= '0;
      end
    end else begin
      pending_q  <= pending_d;
      hold_q     <= hold_d;
      leg_q      <= leg_d;
      fault_q    <= fault_d;
      fault_ch_q <= fault_ch_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output packing.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_CH; i++) begin : g_out_ch
    assign v_filt[i*W +: W] = v_filt_q[i];
  end

  for (genvar k = 0; k < N_LEG; k++) begin : g_out_leg
    assign v_leg_avg[k*W +: W] = leg_q[k];
  end

  assign upd      = upd_q;
  assign ov       = ov_q;
  assign stale    = stale_w;
  assign fault    = fault_q;
  assign fault_ch = fault_ch_q;

endmodule

`default_nettype wire

// File: tb/tb_mmc_cell_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmc_cell_monitor
// Purpose  : Directed self-checking bench for mmc_cell_monitor. Expected
//            filter results come from a sample-history model and are queued
//            when stimulus is driven; a monitor pops and compares them on
//            every upd pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmc_cell_monitor;

  localparam int N_CH     = 6;
  localparam int W        = 8;
  localparam int AVG_LOG2 = 2;
  localparam int V_MAX    = 230;
  localparam int V_HYST   = 10;
  localparam int TIMEOUT  = 1000;
  localparam int N_LEG    = N_CH / 2;
  localparam int CH_W     = $clog2(N_CH);

  logic                  clk_50 = 1'b0;
  logic                  rst;
  logic [N_CH*W-1:0]     rx_data;
  logic [N_CH-1:0]       rx_valid;
  logic                  clr_fault;
  logic [N_CH*W-1:0]     v_filt;
  logic [N_LEG*W-1:0]    v_leg_avg;
  logic [N_CH-1:0]       upd;
  logic [N_CH-1:0]       ov;
  logic [N_CH-1:0]       stale;
  logic                  fault;
  logic [CH_W-1:0]       fault_ch;

  mmc_cell_monitor #(
    .N_CH     (N_CH),
    .W        (W),
    .AVG_LOG2 (AVG_LOG2),
    .V_MAX    (V_MAX),
    .V_HYST   (V_HYST),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_50    (clk_50),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .clr_fault (clr_fault),
    .v_filt    (v_filt),
    .v_leg_avg (v_leg_avg),
    .upd       (upd),
    .ov        (ov),
    .stale     (stale),
    .fault     (fault),
    .fault_ch  (fault_ch)
  );

  always #10 clk_50 = ~clk_50;

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   ch;
    int   filt;
    logic ovf;
  } exp_t;

  exp_t exp_q[$];

  // Model: last four samples per channel, averaged directly.
  int   hist   [N_CH][4];
  int   m_filt [N_CH];
  logic m_ov   [N_CH];

  int upd_total [N_CH];
  int last_upd  [N_CH];
  logic [N_CH-1:0] prev_upd = '0;
  exp_t got;

  int t_drive;
  int t_rst;
  int t0;
  int snap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      for (int k = 0; k < 4; k++) hist[c][k] = 0;
      m_filt[c] = 0;
      m_ov[c]   = 1'b0;
    end
  endtask

  task automatic model_push(input int ch, input int val);
    exp_t e;
    int   s;
    for (int k = 3; k > 0; k--) hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = val;
    s = 0;
    for (int k = 0; k < 4; k++) s += hist[ch][k];
    m_filt[ch] = s / 4;
    if (m_filt[ch] > V_MAX) m_ov[ch] = 1'b1;
    else if (m_filt[ch] < V_MAX - V_HYST) m_ov[ch] = 1'b0;
    e.ch   = ch;
    e.filt = m_filt[ch];
    e.ovf  = m_ov[ch];
    exp_q.push_back(e);
  endtask

  // Drives one strobe cycle on the masked channels; queues expectations in
  // service order (ascending from ptr, which is 0 wherever this is used).
  task automatic drive(input logic [N_CH-1:0] mask, input int val, input bit push);
    @(posedge clk_50); #1;
    t_drive = cyc;
    for (int i = 0; i < N_CH; i++) begin
      rx_valid[i] = mask[i];
      if (mask[i]) rx_data[i*W +: W] = W'(val);
    end
    if (push) begin
      for (int i = 0; i < N_CH; i++) if (mask[i]) model_push(i, val);
    end
    @(posedge clk_50); #1;
    rx_valid = '0;
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) begin
      @(negedge clk_50); #1;
    end
    check("scoreboard_drain", exp_q.size(), 0);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk_50);
  endtask

  task automatic pulse_clr();
    @(posedge clk_50); #1 clr_fault = 1'b1;
    @(posedge clk_50); #1 clr_fault = 1'b0;
    @(negedge clk_50);
  endtask

  task automatic do_reset();
    check("queue_empty_before_reset", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk_50); #1 rst = 1'b1;
    @(posedge clk_50); #1;
    @(posedge clk_50); #1 rst = 1'b0;
    t_rst = cyc;
    model_reset();
  endtask

  // Scoreboard monitor.
  always @(negedge clk_50) begin
    for (int i = 0; i < N_CH; i++) begin
      if (upd[i] === 1'b1) begin
        upd_total[i] = upd_total[i] + 1;
        last_upd[i]  = cyc;
        if (exp_q.size() == 0) begin
          check("upd_unexpected_channel", i, N_CH);
        end else begin
          got = exp_q.pop_front();
          check("upd_channel", i, got.ch);
          check("v_filt", v_filt[i*W +: W], got.filt);
          check("ov_on_upd", ov[i], got.ovf);
        end
      end
    end
    if (|upd) check("upd_back_to_back", upd & prev_upd, 0);
    prev_upd = upd;
  end

  initial begin
    #(20 * 60000);
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    rx_valid  = '0;
    rx_data   = '0;
    clr_fault = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      upd_total[i] = 0;
      last_upd[i]  = 0;
    end
    model_reset();
    do_reset();

    // Reset state.
    @(negedge clk_50);
    check("rst_v_filt", v_filt, 0);
    check("rst_v_leg_avg", v_leg_avg, 0);
    check("rst_upd", upd, 0);
    check("rst_ov", ov, 0);
    check("rst_stale", stale, 0);
    check("rst_fault", fault, 0);
    check("rst_fault_ch", fault_ch, 0);

    // Fill: four samples of 200 on ch0 -> 50, 100, 150, 200.
    snap = upd_total[0];
    for (int n = 0; n < 4; n++) begin
      drive(6'b000001, 200, 1);
      if (n == 0) t0 = t_drive;
      wait_drain(20);
      if (n == 0) check("fill_latency", last_upd[0] - t0, 4);
    end
    check("fill_upd_count", upd_total[0] - snap, 4);
    check("fill_v_filt0", v_filt[0 +: W], 200);
    check("fill_ov0", ov[0], 0);

    // Hysteresis on ch2.
    do_reset();
    for (int n = 0; n < 3; n++) begin
      drive(6'b000100, 236, 1);
      wait_drain(20);
    end
    drive(6'b000100, 236, 1);
    t0 = t_drive;
    wait_until(t0 + 4);
    check("hyst_ov_at_t4", ov[2], 1);
    check("hyst_fault_not_yet", fault, 0);
    wait_until(t0 + 5);
    check("hyst_fault_at_t5", fault, 1);
    check("hyst_fault_ch", fault_ch, 2);
    wait_drain(20);
    for (int n = 0; n < 4; n++) begin
      drive(6'b000100, 225, 1);
      wait_drain(20);
    end
    check("hyst_ov_holds_225", ov[2], 1);
    for (int n = 0; n < 4; n++) begin
      drive(6'b000100, 218, 1);
      wait_drain(20);
    end
    check("hyst_ov_clears_218", ov[2], 0);
    check("hyst_fault_latched", fault, 1);
    check("hyst_fault_ch_held", fault_ch, 2);
    repeat (2) @(negedge clk_50);
    check("hyst_leg1", v_leg_avg[1*W +: W], (m_filt[2] + m_filt[3]) >> 1);
    pulse_clr();
    @(negedge clk_50);
    check("hyst_fault_cleared", fault, 0);

    // Contention: all six channels strobed together with 80.
    do_reset();
    drive(6'b111111, 80, 1);
    t0 = t_drive;
    wait_drain(40);
    for (int k = 0; k < N_CH; k++) begin
      check("contention_spacing", last_upd[k] - t0, 4 + 4 * k);
    end
    repeat (2) @(negedge clk_50);
    for (int k = 0; k < N_LEG; k++) begin
      check("contention_leg_avg", v_leg_avg[k*W +: W], (m_filt[2*k] + m_filt[2*k+1]) >> 1);
    end

    // Overwrite: ch1 gets 100 then 120 while ch0 is being serviced.
    do_reset();
    snap = upd_total[1];
    drive(6'b000001, 50, 1);
    drive(6'b000010, 100, 0);
    drive(6'b000010, 120, 0);
    model_push(1, 120);
    wait_drain(40);
    repeat (8) @(negedge clk_50);
    check("overwrite_single_service", upd_total[1] - snap, 1);
    check("overwrite_v_filt1", v_filt[1*W +: W], 30);

    // Reset during ACC discards the in-flight ch3 sample.
    do_reset();
    drive(6'b001000, 200, 0);
    t0 = t_drive;
    while (cyc < t0 + 3) begin
      @(posedge clk_50); #1;
    end
    rst = 1'b1;
    @(posedge clk_50); #1 rst = 1'b0;
    model_reset();
    @(negedge clk_50);
    check("midrst_v_filt", v_filt, 0);
    check("midrst_upd", upd, 0);
    check("midrst_ov", ov, 0);
    check("midrst_fault", fault, 0);
    drive(6'b100000, 40, 1);
    wait_drain(20);
    repeat (8) @(negedge clk_50);
    check("midrst_v_filt5", v_filt[5*W +: W], 10);
    check("midrst_v_filt3", v_filt[3*W +: W], 0);

    // Stale watchdog: ch4 never receives; the others are refreshed.
    do_reset();
`ifdef MMC_MON_STALE_EN
    for (int r = 0; r < 3; r++) begin
      drive(6'b101111, 0, 1);
      wait_drain(40);
      wait_until(t_rst + 350 * (r + 1));
    end
    wait_until(t_rst + 995);
    check("stale_before_timeout", stale, 0);
    wait_until(t_rst + 1005);
    check("stale_ch4", stale, 6'b010000);
    @(negedge clk_50);
    check("stale_fault", fault, 1);
    check("stale_fault_ch", fault_ch, 4);
    pulse_clr();
    check("stale_clr_ignored", fault, 1);
    drive(6'b010000, 0, 1);
    wait_drain(20);
    check("stale_cleared", stale, 0);
    pulse_clr();
    @(negedge clk_50);
    check("stale_fault_cleared", fault, 0);
`else
    wait_until(t_rst + 1005);
    check("nostale_stale", stale, 0);
    check("nostale_fault", fault, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
